// File: rtl/receiver_buffer_pkg.sv
// rtl/receiver_buffer_pkg.sv - shared widths, types and helpers for the receive buffer
package receiver_buffer_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  // Position of the next byte inside the word being assembled
  typedef enum logic [$clog2(BYTES_PER_WORD)-1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } asm_state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Byte position after one more byte arrives; the last position wraps to the first
  function automatic asm_state_t next_byte(input asm_state_t s);
    asm_state_t n;
    case (s)
      BYTE0:   n = BYTE1;
      BYTE1:   n = BYTE2;
      BYTE2:   n = BYTE3;
      default: n = BYTE0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/receiver_buffer_if.sv
// rtl/receiver_buffer_if.sv - byte input, word pop and status signals of the receive buffer
interface receiver_buffer_if
  import receiver_buffer_pkg::*;
#(
  parameter int BUFFER_DEPTH = 32
);

  localparam int CNT_W = ptr_w(BUFFER_DEPTH) + 1;

  byte_t            in_data;
  logic             in_valid;
  logic             pop;
  logic             clear_err;
  word_t            out_data;
  logic             out_valid;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overrun;
  logic             frag_drop;

  // Side that feeds bytes in and consumes words
  modport master (
    output in_data, in_valid, pop, clear_err,
    input  out_data, out_valid, full, count, overrun, frag_drop
  );

  // The buffer itself
  modport slave (
    input  in_data, in_valid, pop, clear_err,
    output out_data, out_valid, full, count, overrun, frag_drop
  );

endinterface

// File: rtl/receiver_buffer_word_fifo.sv
// rtl/receiver_buffer_word_fifo.sv - word FIFO with first-word-fall-through read and explicit count
module word_fifo
  import receiver_buffer_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CNT_W = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  word_t            wdata_i,
  input  logic             pop_i,
  output word_t            rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o,
  output logic             drop_o
);

  word_t            mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;
  logic             full;
  logic             empty;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_ok);

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + PW'(1);
    if (pop_ok)  head_d = head_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Word storage; contents need no reset because count gates every read
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[head_q];
  assign empty_o = empty;
  assign full_o  = full;
  assign count_o = count_q;
  assign drop_o  = push_i && !push_ok;

endmodule

// File: rtl/receiver_buffer.sv
// rtl/receiver_buffer.sv - packs received bytes MSB-first into words and queues them
module receiver_buffer
  import receiver_buffer_pkg::*;
#(
  parameter int BUFFER_DEPTH   = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             reset,
  receiver_buffer_if.slave bus
);

  localparam int          CNT_W      = ptr_w(BUFFER_DEPTH) + 1;
  localparam int          SH_W       = WORD_W - BYTE_W;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] IDLE_LAST  = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  asm_state_t       asm_q, asm_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic [31:0]      idle_q, idle_d;
  logic             overrun_q, overrun_d;
  logic             frag_q, frag_d;
  logic             timeout;
  logic             push;
  word_t            word;
  word_t            fifo_rdata;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_drop;

  // The partial word is abandoned once it has sat idle for the full timeout window
  assign timeout = TIMEOUT_EN && (asm_q != BYTE0) && (idle_q == IDLE_LAST);

  // Assembler and idle counter next-state; a byte arriving in the timeout cycle starts a new word
  always_comb begin
    asm_d  = asm_q;
    sh_d   = sh_q;
    idle_d = idle_q;
    push   = 1'b0;
    word   = {sh_q, bus.in_data};
    if (timeout) asm_d = BYTE0;
    if (bus.in_valid) begin
      sh_d  = {sh_q[SH_W-BYTE_W-1:0], bus.in_data};
      asm_d = next_byte(timeout ? BYTE0 : asm_q);
      push  = !timeout && (asm_q == BYTE3);
    end
    if (bus.in_valid || (asm_q == BYTE0) || timeout) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 32'd1;
    end
  end

  // Sticky error flags; a new error outranks a clear in the same cycle
  always_comb begin
    overrun_d = bus.clear_err ? 1'b0 : overrun_q;
    frag_d    = bus.clear_err ? 1'b0 : frag_q;
    if (fifo_drop) overrun_d = 1'b1;
    if (timeout)   frag_d    = 1'b1;
  end

  // Assembler, idle counter and error flag registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      asm_q     <= BYTE0;
      sh_q      <= '0;
      idle_q    <= '0;
      overrun_q <= 1'b0;
      frag_q    <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      sh_q      <= sh_d;
      idle_q    <= idle_d;
      overrun_q <= overrun_d;
      frag_q    <= frag_d;
    end
  end

  word_fifo #(
    .DEPTH(BUFFER_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (bus.pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  assign bus.out_data  = fifo_rdata;
  assign bus.out_valid = !fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.count     = fifo_count;
  assign bus.overrun   = overrun_q;
  assign bus.frag_drop = frag_q;

endmodule

// File: tb/tb_receiver_buffer.sv
// tb/tb_receiver_buffer.sv - randomized and directed bench for receiver_buffer against a queue model
module tb_receiver_buffer;
  import receiver_buffer_pkg::*;

  localparam int DEPTH = 32;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  receiver_buffer_if #(.BUFFER_DEPTH(DEPTH)) bus();

  receiver_buffer #(
    .BUFFER_DEPTH   (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  word_t mq[$];
  byte_t pb[$];
  int    cyc      = 0;
  int    last_cyc = 0;
  bit    m_ovr    = 1'b0;
  bit    m_frag   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference: bytes collect in a list, four make a word, words live in a bounded queue
  task automatic model(input bit v, input byte_t d, input bit p, input bit c, input bit r);
    bit    have_word;
    word_t w;
    have_word = 1'b0;
    w = '0;
    if (r) begin
      mq.delete();
      pb.delete();
      m_ovr  = 1'b0;
      m_frag = 1'b0;
    end else begin
      if (c) begin
        m_ovr  = 1'b0;
        m_frag = 1'b0;
      end
      if (pb.size() != 0 && (cyc - last_cyc) == TMO) begin
        pb.delete();
        m_frag = 1'b1;
      end
      if (v) begin
        pb.push_back(d);
        last_cyc = cyc;
        if (pb.size() == 4) begin
          w = {pb[0], pb[1], pb[2], pb[3]};
          pb.delete();
          have_word = 1'b1;
        end
      end
      if (p && mq.size() != 0) void'(mq.pop_front());
      if (have_word) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovr = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    check("out_data",  bus.out_data, (mq.size() != 0) ? mq[0] : 32'h0);
    check("count",     32'(bus.count), 32'(mq.size()));
    check("full",      32'(bus.full), 32'(mq.size() == DEPTH));
    check("overrun",   32'(bus.overrun), 32'(m_ovr));
    check("frag_drop", 32'(bus.frag_drop), 32'(m_frag));
  endtask

  task automatic step(input bit v, input byte_t d, input bit p, input bit c, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.pop       = p;
    bus.clear_err = c;
    rst           = r;
    @(posedge clk);
    model(v, d, p, c, r);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input byte_t d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input word_t w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_full"},  32'(bus.full), 32'd0);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_ovr"},   32'(bus.overrun), 32'd0);
    check({tag, "_frag"},  32'(bus.frag_drop), 32'd0);
    check({tag, "_data"},  bus.out_data, 32'd0);
  endtask

  int vp_tab [5] = '{90, 50, 30, 5, 100};
  int pp_tab [5] = '{10, 50, 60, 30, 0};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.pop       = 1'b0;
    bus.clear_err = 1'b0;
    rst           = 1'b1;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_reset_values("rst");

    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("beef_data",  bus.out_data, 32'hDEADBEEF);
    check("beef_count", 32'(bus.count), 32'd1);
    do_pop();
    check("beef_popped", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < DEPTH; i++) send_word(32'(i));
    check("fill_full",  32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd32);
    send_word(32'hFFFFFFFF);
    check("fill_ovr", 32'(bus.overrun), 32'd1);
    do_clear();
    check("ovr_clr", 32'(bus.overrun), 32'd0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    step(1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
    check("pp_count", 32'(bus.count), 32'd32);
    check("pp_full",  32'(bus.full), 32'd1);
    check("pp_ovr",   32'(bus.overrun), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      check("drain", bus.out_data, 32'(i));
      do_pop();
    end
    check("drain_last", bus.out_data, 32'h12345678);
    do_pop();
    check("drain_empty", 32'(bus.out_valid), 32'd0);

    send_byte(8'h11); send_byte(8'h22);
    idle(20);
    check("tmo_frag",  32'(bus.frag_drop), 32'd1);
    check("tmo_empty", 32'(bus.count), 32'd0);
    send_word(32'hA1B2C3D4);
    check("tmo_word", bus.out_data, 32'hA1B2C3D4);
    do_pop();
    do_clear();
    check("tmo_clr", 32'(bus.frag_drop), 32'd0);

    send_byte(8'h55);
    idle(TMO - 1);
    send_byte(8'h66);
    check("tmo_edge_frag", 32'(bus.frag_drop), 32'd1);
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    check("tmo_edge_word",  bus.out_data, 32'h66778899);
    check("tmo_edge_count", 32'(bus.count), 32'd1);
    do_pop();
    do_clear();

    send_word(32'h1); send_word(32'h2); send_word(32'h3);
    send_byte(8'hAA); send_byte(8'hBB);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_reset_values("midrst");
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("midrst_word",  bus.out_data, 32'h01020304);
    check("midrst_count", 32'(bus.count), 32'd1);
    do_pop();
    do_pop();
    check("empty_pop", 32'(bus.count), 32'd0);

    for (int i = 0; i < DEPTH; i++) send_word($urandom);
    send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
    step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    check("ovr_vs_clr", 32'(bus.overrun), 32'd1);
    do_clear();
    for (int i = 0; i < DEPTH; i++) do_pop();

    for (int ph = 0; ph < 5; ph++) begin
      for (int n = 0; n < 600; n++) begin
        step($urandom_range(99) < vp_tab[ph], byte_t'($urandom),
             $urandom_range(99) < pp_tab[ph], $urandom_range(99) < 2,
             $urandom_range(999) < 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/receiver_buffer.md
# receiver_buffer

Byte-to-word receive buffer on the UART input path. Packs bytes from the UART receiver, most significant byte first, into 32-bit words, then queues them in a FIFO. The core reads words through a first-word-fall-through pop interface. It is the receive-side counterpart of the word-to-byte transmit buffer and uses the same byte order.

## Interface
- BUFFER_DEPTH, 32, FIFO depth in words; power of two, ≥2
- TIMEOUT_CYCLES, 1_000_000, idle cycles after which a partial word is discarded; 0 disables the timeout
- CLK  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high
- in_data  input  8  received byte
- in_valid  input  1  one-cycle strobe, in_data valid
- pop  input  1  core consumes the head word
- clear_err  input  1  clears the sticky error flags
- out_data  output  32  head word; meaningful only while out_valid=1
- out_valid  output  1  FIFO not empty
- full  output  1  FIFO holds BUFFER_DEPTH words
- count  output  $clog2(BUFFER_DEPTH)+1  words currently stored
- overrun  output  1  sticky: a completed word was dropped because the FIFO was full
- frag_drop  output  1  sticky: a partial word was discarded by timeout

## Operation
- Reset values: out_valid=0, full=0, count=0, overrun=0, frag_drop=0, out_data=0.
- Reset also clears the pointers, byte counter, shift register and idle counter. A word being assembled when reset is asserted is lost.
- Assembler states are byte_cnt ∈ {0,1,2,3}. Every in_valid shifts the register (sh <= {sh[23:0], in_data}) and advances byte_cnt, wrapping 3→0.
- The in_valid that brings byte_cnt from 3 to 0 completes a word, {sh[23:0], in_data}, and generates a push in that same cycle.
- Byte order: the first byte received goes to [31:24] and the fourth byte to [7:0].
- Push when not full: write mem[tail] and increment tail. The pointer is $clog2(BUFFER_DEPTH) bits and wraps naturally.
- Push when full and pop=0: the word is dropped, overrun is set to 1, and tail and count are unchanged.
- Push and pop in the same cycle: both are accepted, including when the FIFO is full. count is unchanged and full stays 1.
- Pop with out_valid=1 increments head. Pop with out_valid=0 is ignored and has no error.
- out_data is mem[head], a combinational read from the registered head.
- count is tracked explicitly: +1 for an accepted push, −1 for an accepted pop, unchanged when both occur.
- full = (count==BUFFER_DEPTH). out_valid = (count!=0).
- Timeout:
  - The idle counter is cleared by any in_valid or when byte_cnt==0.
  - It increments each cycle while byte_cnt≠0.
  - When it reaches TIMEOUT_CYCLES−1, the next cycle sets byte_cnt=0, sets frag_drop=1 and leaves the FIFO unchanged.
  - If in_valid arrives in the timeout cycle, the byte is kept: byte_cnt becomes 1 and frag_drop is still set.
- clear_err clears overrun and frag_drop. If a new error occurs in the same cycle, the set wins.

## Timing
- Push latency: 4th-byte in_valid at cycle N gives out_valid=1 and out_data valid at cycle N+1 (FIFO previously empty).
- Pop at cycle N: the next word, or out_valid=0, is visible at N+1.
- Throughput is one push and one pop per cycle. in_valid may be asserted on consecutive cycles.
- There is no backpressure toward the UART receiver. Loss of data is reported only through overrun.

## Structure
- Package receiver_buffer_pkg:
  - WORD_W=32, BYTE_W=8, BYTES_PER_WORD=4
  - typedef word_t (logic [31:0]) and byte_t
  - function ptr_w(depth) returning $clog2(depth)
- Sub-module word_fifo #(DEPTH): storage, head and tail pointers, count, full/empty, and the simultaneous push/pop rule.
- receiver_buffer contains the assembler, the timeout counter, the error flags and one word_fifo instance.

## Test plan
- Bytes 0xDE,0xAD,0xBE,0xEF on consecutive cycles → one cycle after 0xEF, out_valid=1, out_data=0xDEADBEEF, count=1. pop → out_valid=0 next cycle.
- Push 32 words 0x00000000..0x0000001F (BUFFER_DEPTH=32) → full=1, count=32. A 33rd word 0xFFFFFFFF → overrun=1. Popping returns words 0..31 in order with no 0xFFFFFFFF.
- Full FIFO, 4th byte and pop in the same cycle → count stays 32, overrun=0, and the new word is read last. Also covers tail/head wrap past index 31.
- TIMEOUT_CYCLES=16: send 0x11,0x22, idle 20 cycles → frag_drop=1, FIFO empty. Then 0xA1,0xB2,0xC3,0xD4 → out_data=0xA1B2C3D4. clear_err → frag_drop=0.
- Assert reset after 2 bytes with 3 words stored → all outputs at reset values. The next 4 bytes 0x01,0x02,0x03,0x04 → out_data=0x01020304.
- Pop on empty and clear_err coincident with overrun → no state change for the pop, and overrun remains 1.
